// File: rtl/result_writer_pkg.sv
// Shared definitions for the result writer and its readers (input_selector).
// Nibble i of the flat bank occupies bits [4i+3:4i].
package result_writer_pkg;

  localparam int NIBBLES = 64;
  localparam int ADDR_W  = 6;
  localparam int NIB_W   = 4;
  localparam int BANK_W  = NIBBLES * NIB_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wrState_e;

  function automatic int unsigned nibLsb(input logic [ADDR_W-1:0] idx);
    return int'(idx) * NIB_W;
  endfunction

endpackage

// File: rtl/result_writer_if.sv
// Burst-write bus between a nibble producer and result_writer.
interface result_writer_if;
  import result_writer_pkg::*;

  logic              wStart;
  logic [ADDR_W-1:0] wBaseAddr;
  logic [ADDR_W-1:0] wCount;
  logic              wClear;
  logic              wValid;
  logic [NIB_W-1:0]  wNibble;
  logic              wReady;
  logic              wBusy;
  logic              wDone;
  logic [BANK_W-1:0] wDataRegs;

  modport master (
    output wStart, wBaseAddr, wCount, wClear, wValid, wNibble,
    input  wReady, wBusy, wDone, wDataRegs
  );

  modport slave (
    input  wStart, wBaseAddr, wCount, wClear, wValid, wNibble,
    output wReady, wBusy, wDone, wDataRegs
  );

endinterface

// File: rtl/result_writer_nibble_bank.sv
// 64x4 nibble storage: one write port, synchronous clear, async reset, flat output.
module nibble_bank #(
  parameter int NIBBLES = result_writer_pkg::NIBBLES,
  parameter int ADDR_W  = result_writer_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [3:0]           data,
  output logic [NIBBLES*4-1:0] regs
);
  import result_writer_pkg::*;

  // Clear and write never coincide: clear is only honoured in IDLE, writes only in WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else if (clear) begin
      regs <= '0;
    end else if (we) begin
      regs[nibLsb(addr) +: 4] <= data;
    end
  end

endmodule

// File: rtl/result_writer.sv
// Burst writer: packs handshaken nibbles into consecutive (mod 64) bank entries.
module result_writer #(
  parameter int NIBBLES = result_writer_pkg::NIBBLES,
  parameter int ADDR_W  = result_writer_pkg::ADDR_W
) (
  input  logic            clk,
  input  logic            reset,
  result_writer_if.slave  bus
);
  import result_writer_pkg::*;

  wrState_e          state, stateNext;
  logic [ADDR_W-1:0] ptr, ptrNext;
  logic [ADDR_W-1:0] rem, remNext;
  logic              bankWe;
  logic              bankClr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
      rem   <= '0;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
      rem   <= remNext;
    end
  end

  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    remNext   = rem;
    bankWe    = 1'b0;
    bankClr   = 1'b0;
    case (state)
      ST_IDLE: begin
        bankClr = bus.wClear;
        if (bus.wStart) begin
          ptrNext   = bus.wBaseAddr;
          remNext   = bus.wCount;
          stateNext = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // wReady is 1 throughout WRITE, so a handshake is just wValid here.
        if (bus.wValid) begin
          bankWe  = 1'b1;
          ptrNext = ptr + ADDR_W'(1);
          if (rem == '0) stateNext = ST_DONE;
          else           remNext   = rem - ADDR_W'(1);
        end
      end
      ST_DONE:  stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  // Outputs decode state only; no input reaches an output combinationally.
  assign bus.wReady = (state == ST_WRITE);
  assign bus.wBusy  = (state != ST_IDLE);
  assign bus.wDone  = (state == ST_DONE);

  nibble_bank #(
    .NIBBLES (NIBBLES),
    .ADDR_W  (ADDR_W)
  ) uBank (
    .clk   (clk),
    .reset (reset),
    .clear (bankClr),
    .we    (bankWe),
    .addr  (ptr),
    .data  (bus.wNibble),
    .regs  (bus.wDataRegs)
  );

endmodule

// File: doc/result_writer.md
# result_writer

Packs 4-bit result nibbles into the 256-bit nibble register bank (`wDataRegs`) that `input_selector` reads from. Each burst starts at a base nibble address and writes a programmed number of consecutive nibbles, one per accepted handshake. The address wraps modulo 64. While a burst is in progress, `wBusy` is driven high, and the selector consumes that signal directly.

## Interface
Parameters:
- `NIBBLES`, 64, number of 4-bit entries in the bank
- `ADDR_W`, 6, nibble address width (log2 of `NIBBLES`)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `wStart`  in  1  start a burst (sampled only in IDLE)
- `wBaseAddr`  in  6  first nibble index of the burst
- `wCount`  in  6  burst length minus one (0 → 1 nibble, 63 → 64 nibbles)
- `wClear`  in  1  zero the whole bank (sampled only in IDLE)
- `wValid`  in  1  `wNibble` carries a nibble to write
- `wNibble`  in  4  nibble data
- `wReady`  out  1  writer accepts `wNibble` this cycle
- `wBusy`  out  1  burst in progress
- `wDone`  out  1  one-cycle pulse: burst complete
- `wDataRegs`  out  256  register bank; nibble i occupies bits [4i+3:4i]

## Operation
- State machine with three states: IDLE, WRITE, DONE.
- **IDLE**
  - Outputs: `wReady`=0, `wBusy`=0, `wDone`=0.
  - On `wStart`=1: latch ptr←`wBaseAddr` and rem←`wCount`, then go to WRITE.
  - On `wClear`=1: `wDataRegs`←0 at the next edge.
  - Both `wClear` and `wStart` asserted in the same cycle: both take effect (bank cleared, burst starts).
- **WRITE**
  - Outputs: `wReady`=1, `wBusy`=1.
  - A handshake occurs when `wValid`&&`wReady`. On each handshake:
    - `wDataRegs[4*ptr+:4]`←`wNibble`
    - ptr←(ptr+1) mod 64
    - if rem==0, go to DONE; otherwise rem←rem−1
  - `wValid`=0 stalls with no state change.
  - `wStart` and `wClear` are ignored.
- **DONE**
  - Outputs: `wDone`=1, `wBusy`=1, `wReady`=0.
  - Unconditionally returns to IDLE on the next cycle.
  - `wStart` is ignored in this state.
- Only the addressed nibble changes on a handshake; all other bits hold.
- Address arithmetic is 6-bit unsigned with natural wrap: 63+1 → 0.
- A 64-nibble burst with base b writes every nibble exactly once and ends with ptr=b.

## Timing
- Reset values: state=IDLE, `wDataRegs`=0, `wReady`=0, `wBusy`=0, `wDone`=0, ptr=0, rem=0.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- `wStart` sampled at edge t → `wBusy` and `wReady` high from t+1.
- Handshake at edge t → new nibble visible on `wDataRegs` after t.
- Last handshake at edge t → DONE during cycle t..t+1 (`wDone` high for exactly one cycle) → IDLE after t+1.
- Minimum burst: start, one handshake, done. Back-to-back: the next `wStart` is accepted one cycle after `wDone`.
- Reset asserted mid-burst: immediately IDLE, bank zeroed, no `wDone` pulse.

## Structure
- A shared package or include holds:
  - state encodings: IDLE=2'd0, WRITE=2'd1, DONE=2'd2
  - `NIBBLES` and `ADDR_W`
  - the nibble-slice convention (bits [4i+3:4i]), shared with `input_selector`
- One natural sub-module, `nibble_bank`: the 64×4 storage with a single write port (write enable, address, data), an async reset/clear, and the full 256-bit flat output.
- FSM, pointer and remaining counter live in `result_writer`.

## Test plan
- Reset, then single nibble: `wBaseAddr`=0, `wCount`=0, `wNibble`=4'hA with `wValid`=1 → `wDataRegs`=256'h…000A, `wDone` pulses once, `wBusy` low again 2 cycles after the handshake.
- Wrap-around: base=62, count=3, nibbles 1,2,3,4 → nibbles 62,63,0,1 hold 1,2,3,4; all others 0.
- Stall: base=5, count=1, `wValid` toggled 1,0,0,1 with data 7,x,x,9 → nibble5=7, nibble6=9; `wDone` only after the second handshake.
- Ignored controls: during WRITE, pulse `wStart` (base=20) and `wClear` → no restart, bank not cleared, burst completes at its original addresses.
- Full burst: base=10, count=63, nibble i = i[3:0] → every nibble written once; a following `input_selector` read at index 10 returns 0.
- Reset mid-burst after 3 of 8 nibbles → `wDataRegs`=0, `wBusy`=0, no `wDone`; a new burst after deassertion works normally.
